seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 117 +++++++++++
 tb/tb_seg_scan_driver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with anti-ghost blanking,
// frame-synchronous double buffering and optional leading-zero suppression.
module seg_scan_driver #(
  parameter int REFRESH_CLKS = 100000,
  parameter int BLANK_CLKS   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int CNT_W = $clog2(REFRESH_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_CLKS - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CLKS);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  logic [15:0]      shadow;
  logic [3:0]       shadow_dp;
  logic [15:0]      pend_value;
  logic [3:0]       pend_dp;
  logic             pending;

  logic             cnt_wrap;
  logic [3:0]       nibble;
  logic [3:0]       lz_chain;
  logic             slot_blank;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  assign cnt_wrap = (cnt == CNT_LAST);
  assign frame    = !rst && (idx == 2'd3) && cnt_wrap;

  // lz_chain[n] is set when digit n and every digit above it would show nothing.
  always_comb begin
    nibble      = shadow[{idx, 2'b00} +: 4];
    lz_chain[3] = (shadow[15:12] == 4'h0) && !shadow_dp[3];
    lz_chain[2] = lz_chain[3] && (shadow[11:8] == 4'h0) && !shadow_dp[2];
    lz_chain[1] = lz_chain[2] && (shadow[7:4] == 4'h0) && !shadow_dp[1];
    lz_chain[0] = 1'b0;
    slot_blank  = (cnt < CNT_BLANK) || (blank_lz && lz_chain[idx]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      shadow     <= 16'h0000;
      shadow_dp  <= 4'h0;
      pend_value <= 16'h0000;
      pend_dp    <= 4'h0;
      pending    <= 1'b0;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
    end else begin
      cnt <= cnt_wrap ? '0 : cnt + 1'b1;
      if (cnt_wrap)
        idx <= idx + 2'd1;

      if (load) begin
        pend_value <= value;
        pend_dp    <= dp_mask;
      end

      // A load landing on the frame edge bypasses the pending stage entirely.
      if (frame && load) begin
        shadow    <= value;
        shadow_dp <= dp_mask;
        pending   <= 1'b0;
      end else if (frame && pending) begin
        shadow    <= pend_value;
        shadow_dp <= pend_dp;
        pending   <= 1'b0;
      end else if (load) begin
        pending   <= 1'b1;
      end

      if (slot_blank) begin
        an  <= 4'b1111;
        seg <= 7'h7F;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= hex_decode(nibble);
        dp  <= ~shadow_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver at REFRESH_CLKS=8, BLANK_CLKS=2: directed table,
// hand-written corner sequences and random traffic against a scan-position model.
module tb_seg_scan_driver;

  localparam int RC = 8;
  localparam int BC = 2;

  logic        clk = 1'b0;
  logic        rst, load, blank_lz;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp, frame;

  int vectors = 0;
  int miscompares = 0;

  seg_scan_driver #(.REFRESH_CLKS(RC), .BLANK_CLKS(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .an(an), .seg(seg), .dp(dp), .frame(frame)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: clocks since reset, plus displayed and queued data.
  int          n_m = 0;
  logic [15:0] shadow_m = '0, pend_m = '0;
  logic [3:0]  shadow_dp_m = '0, pend_dp_m = '0;
  logic        pending_m = 1'b0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dpm;
    logic        blz;
    int          digit;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
  } vec_t;
  vec_t vecs [24];

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at a falling edge; leaves at the next falling edge.
  task automatic applyStimulus(input logic r, input logic l, input logic [15:0] v,
                               input logic [3:0] m, input logic b);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, is_frame;
    int pos, d, off;
    rst = r; load = l; value = v; dp_mask = m; blank_lz = b;
    #1;
    pos = n_m % (4 * RC);
    d = pos / RC;
    off = pos % RC;
    is_frame = !r && (pos == 4 * RC - 1);
    checkOutput("frame", {15'b0, frame}, {15'b0, is_frame});
    e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
    if (!r && off >= BC &&
        !(b && d > 0 && (shadow_m >> (4 * d)) == 0 && (shadow_dp_m >> d) == 0)) begin
      e_an  = ~(4'b0001 << d);
      e_seg = hex_tab[(shadow_m >> (4 * d)) & 16'hF];
      e_dp  = !shadow_dp_m[d];
    end
    if (r) begin
      n_m = 0; shadow_m = '0; shadow_dp_m = '0; pend_m = '0; pend_dp_m = '0; pending_m = 1'b0;
    end else begin
      if (is_frame && l) begin
        shadow_m = v; shadow_dp_m = m; pending_m = 1'b0;
      end else begin
        if (is_frame && pending_m) begin
          shadow_m = pend_m; shadow_dp_m = pend_dp_m; pending_m = 1'b0;
        end
        if (l) begin
          pend_m = v; pend_dp_m = m; pending_m = 1'b1;
        end
      end
      n_m++;
    end
    @(posedge clk);
    #1;
    checkOutput("an", {12'b0, an}, {12'b0, e_an});
    checkOutput("seg", {9'b0, seg}, {9'b0, e_seg});
    checkOutput("dp", {15'b0, dp}, {15'b0, e_dp});
    @(negedge clk);
  endtask

  task automatic runIdle(input int count, input logic b);
    for (int i = 0; i < count; i++)
      applyStimulus(1'b0, 1'b0, 16'h0, 4'h0, b);
  endtask

  task automatic resetDut();
    applyStimulus(1'b1, 1'b0, 16'hFFFF, 4'hF, 1'b0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_mask = '0; blank_lz = 1'b0;
    vecs[0]  = '{16'h1A2F, 4'b0100, 1'b0, 0, 4'b1110, 7'h0E, 1'b1};
    vecs[1]  = '{16'h1A2F, 4'b0100, 1'b0, 1, 4'b1101, 7'h24, 1'b1};
    vecs[2]  = '{16'h1A2F, 4'b0100, 1'b0, 2, 4'b1011, 7'h08, 1'b0};
    vecs[3]  = '{16'h1A2F, 4'b0100, 1'b0, 3, 4'b0111, 7'h79, 1'b1};
    vecs[4]  = '{16'h0050, 4'b0000, 1'b1, 3, 4'b1111, 7'h7F, 1'b1};
    vecs[5]  = '{16'h0050, 4'b0000, 1'b1, 2, 4'b1111, 7'h7F, 1'b1};
    vecs[6]  = '{16'h0050, 4'b0000, 1'b1, 1, 4'b1101, 7'h12, 1'b1};
    vecs[7]  = '{16'h0050, 4'b0000, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
    vecs[8]  = '{16'h0000, 4'b0000, 1'b1, 1, 4'b1111, 7'h7F, 1'b1};
    vecs[9]  = '{16'h0000, 4'b0000, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
    vecs[10] = '{16'h0000, 4'b1000, 1'b1, 2, 4'b1011, 7'h40, 1'b1};
    vecs[11] = '{16'h0000, 4'b1000, 1'b1, 3, 4'b0111, 7'h40, 1'b0};
    vecs[12] = '{16'h3456, 4'b0000, 1'b0, 0, 4'b1110, 7'h02, 1'b1};
    vecs[13] = '{16'h3456, 4'b0000, 1'b0, 1, 4'b1101, 7'h12, 1'b1};
    vecs[14] = '{16'h3456, 4'b0000, 1'b0, 2, 4'b1011, 7'h19, 1'b1};
    vecs[15] = '{16'h3456, 4'b0000, 1'b0, 3, 4'b0111, 7'h30, 1'b1};
    vecs[16] = '{16'h789B, 4'b0001, 1'b0, 0, 4'b1110, 7'h03, 1'b0};
    vecs[17] = '{16'h789B, 4'b0001, 1'b0, 1, 4'b1101, 7'h10, 1'b1};
    vecs[18] = '{16'h789B, 4'b0001, 1'b0, 2, 4'b1011, 7'h00, 1'b1};
    vecs[19] = '{16'h789B, 4'b0001, 1'b0, 3, 4'b0111, 7'h78, 1'b1};
    vecs[20] = '{16'hCDE0, 4'b0000, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
    vecs[21] = '{16'hCDE0, 4'b0000, 1'b1, 1, 4'b1101, 7'h06, 1'b1};
    vecs[22] = '{16'hCDE0, 4'b0000, 1'b1, 2, 4'b1011, 7'h21, 1'b1};
    vecs[23] = '{16'hCDE0, 4'b0000, 1'b1, 3, 4'b0111, 7'h46, 1'b1};

    @(negedge clk);
    resetDut();
    resetDut();
    checkOutput("reset_an", {12'b0, an}, 16'h000F);
    checkOutput("reset_seg", {9'b0, seg}, 16'h007F);

    // Idle scan after reset: two full frames of zeros.
    runIdle(64, 1'b0);

    // Table: load, wait through the transfer frame, sample mid-slot of the target digit.
    foreach (vecs[i]) begin
      resetDut();
      for (int k = 0; k <= 4 * RC + vecs[i].digit * RC + 4; k++)
        applyStimulus(1'b0, k == 0, vecs[i].value, vecs[i].dpm, vecs[i].blz);
      checkOutput("tbl_an", {12'b0, an}, {12'b0, vecs[i].exp_an});
      checkOutput("tbl_seg", {9'b0, seg}, {9'b0, vecs[i].exp_seg});
      checkOutput("tbl_dp", {15'b0, dp}, {15'b0, vecs[i].exp_dp});
    end

    // Two loads in one scan: last one wins; then a load on the frame cycle.
    resetDut();
    runIdle(3, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h1111, 4'h0, 1'b0);
    runIdle(6, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h2222, 4'h0, 1'b0);
    runIdle(37 - 10, 1'b0);
    checkOutput("last_load_wins", {9'b0, seg}, 16'h0024);
    runIdle(63 - 38, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0777, 4'h0, 1'b0);
    runIdle(4, 1'b0);
    checkOutput("frame_load_seg", {9'b0, seg}, 16'h0078);
    checkOutput("frame_load_an", {12'b0, an}, 16'h000E);

    // Reset during digit 2 with data pending: pending is discarded.
    resetDut();
    runIdle(5, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h8888, 4'hF, 1'b0);
    runIdle(20 - 6, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h9999, 4'hF, 1'b0);
    checkOutput("rst_mid_an", {12'b0, an}, 16'h000F);
    checkOutput("rst_mid_dp", {15'b0, dp}, 16'h0001);
    runIdle(5, 1'b0);
    checkOutput("restart_an", {12'b0, an}, 16'h000E);
    checkOutput("restart_seg", {9'b0, seg}, 16'h0040);
    runIdle(32, 1'b0);
    checkOutput("no_pending_seg", {9'b0, seg}, 16'h0040);
    checkOutput("no_pending_dp", {15'b0, dp}, 16'h0001);

    // Random traffic, zero-heavy values to exercise blanking.
    for (int i = 0; i < 1500; i++) begin
      logic [15:0] v;
      logic [3:0]  m;
      v = 16'($urandom);
      if ($urandom_range(1, 0) == 1) v = v & (16'hFFFF >> (4 * $urandom_range(4, 1)));
      m = ($urandom_range(3, 0) == 0) ? 4'($urandom) : 4'h0;
      applyStimulus($urandom_range(199, 0) == 0, $urandom_range(9, 0) == 0, v, m,
                    $urandom_range(7, 0) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
